// File: rtl/data_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : data_bus_arbiter_if
// Description: Bundles the signals of the two-master data bus arbiter.
//              There are two requester ports, M0 (the core) and M1 (the
//              loader/debug master), plus the memory command/return port
//              and a busy flag.
//              slave  modport : arbiter side (takes requests, drives memory)
//              master modport : environment side (requesters + memory)
//              Ports per requester Mx:
//                iMx_Req, iMx_WrEn, iMx_Addr, iMx_WrData, iMx_Funct3 (in)
//                oMx_Gnt, oMx_RdValid, oMx_RdData                    (out)
//              Memory: oMem_WrEn/Addr/WrData/Funct3 (out), iMem_RdData (in)
// Revision   : 1.0  initial release
// ============================================================================
interface data_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iM0_Req;
    logic              iM0_WrEn;
    logic [ADDR_W-1:0] iM0_Addr;
    logic [DATA_W-1:0] iM0_WrData;
    logic [2:0]        iM0_Funct3;
    logic              oM0_Gnt;
    logic              oM0_RdValid;
    logic [DATA_W-1:0] oM0_RdData;

    logic              iM1_Req;
    logic              iM1_WrEn;
    logic [ADDR_W-1:0] iM1_Addr;
    logic [DATA_W-1:0] iM1_WrData;
    logic [2:0]        iM1_Funct3;
    logic              oM1_Gnt;
    logic              oM1_RdValid;
    logic [DATA_W-1:0] oM1_RdData;

    logic              oMem_WrEn;
    logic [ADDR_W-1:0] oMem_Addr;
    logic [DATA_W-1:0] oMem_WrData;
    logic [2:0]        oMem_Funct3;
    logic [DATA_W-1:0] iMem_RdData;
    logic              oBusy;

    modport slave (
        input  iM0_Req, iM0_WrEn, iM0_Addr, iM0_WrData, iM0_Funct3,
        output oM0_Gnt, oM0_RdValid, oM0_RdData,
        input  iM1_Req, iM1_WrEn, iM1_Addr, iM1_WrData, iM1_Funct3,
        output oM1_Gnt, oM1_RdValid, oM1_RdData,
        output oMem_WrEn, oMem_Addr, oMem_WrData, oMem_Funct3,
        input  iMem_RdData,
        output oBusy
    );

    modport master (
        output iM0_Req, iM0_WrEn, iM0_Addr, iM0_WrData, iM0_Funct3,
        input  oM0_Gnt, oM0_RdValid, oM0_RdData,
        output iM1_Req, iM1_WrEn, iM1_Addr, iM1_WrData, iM1_Funct3,
        input  oM1_Gnt, oM1_RdValid, oM1_RdData,
        input  oMem_WrEn, oMem_Addr, oMem_WrData, oMem_Funct3,
        output iMem_RdData,
        input  oBusy
    );
endinterface
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : data_bus_arbiter
// Description: Shares the single data-memory port between M0 (RV32I core
//              load/store port) and M1 (loader/debug master). One
//              transaction at a time: grant in IDLE, one command cycle in
//              ISSUE, and for reads a wait of RD_LATENCY cycles before the
//              memory data is returned to the owner only.
//              Ports: iClk, iRst (sync, active high), bus (slave modport of
//              data_bus_arbiter_if).
//              Build option: DBUS_ARB_FIXED_PRIO_EN selects fixed priority
//              (M0 wins ties); otherwise round-robin.
//              Parameters: ADDR_W, DATA_W, RD_LATENCY (legal 1..4).
// Revision   : 1.0  initial release
// ============================================================================
module data_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  wire logic             iClk,
    input  wire logic             iRst,
    data_bus_arbiter_if.slave     bus
);
    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_ISSUE   = 2'd1;
    localparam logic [1:0] c_S_RD_WAIT = 2'd2;

    // The wait counter ends at 0 in the cycle the read data is valid.
    localparam logic [1:0] c_LAT_INIT  = 2'(RD_LATENCY - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [1:0]        r_lat;
    logic              r_owner;       // 0 = M0, 1 = M1
    logic              r_mem_wren;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wrdata;
    logic [2:0]        r_mem_funct3;

    logic              w_any_req;
    logic              w_sel_m1;
    logic              w_grant;
    logic              w_rd_valid;

    assign w_any_req = bus.iM0_Req | bus.iM1_Req;
    // Grants are suppressed while reset is asserted so every output is 0.
    assign w_grant   = (r_state == c_S_IDLE) & w_any_req & ~iRst;

`ifdef DBUS_ARB_FIXED_PRIO_EN
    assign w_sel_m1 = bus.iM1_Req & ~bus.iM0_Req;
`else
    // Remembers who was served last; resets to M1 so M0 wins the first tie.
    logic r_last_m1;

    assign w_sel_m1 = bus.iM1_Req & (~bus.iM0_Req | ~r_last_m1);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_last_m1 <= 1'b1;
        end else if (w_grant) begin
            r_last_m1 <= w_sel_m1;
        end
    end
`endif

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:    if (w_grant) w_next_state = c_S_ISSUE;
            c_S_ISSUE:   w_next_state = r_mem_wren ? c_S_IDLE : c_S_RD_WAIT;
            c_S_RD_WAIT: if (r_lat == 2'd0) w_next_state = c_S_IDLE;
            default:     w_next_state = c_S_IDLE;
        endcase
    end

    // Command latch and read-latency counter. The winner's command is
    // captured straight into the memory-side registers so it appears on
    // oMem_* in the ISSUE cycle and is held there afterwards; only the
    // write strobe is cleared again after one cycle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_lat        <= 2'd0;
            r_owner      <= 1'b0;
            r_mem_wren   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wrdata <= '0;
            r_mem_funct3 <= 3'd0;
        end else begin
            r_mem_wren <= 1'b0;
            if (w_grant) begin
                r_owner <= w_sel_m1;
                if (w_sel_m1) begin
                    r_mem_wren   <= bus.iM1_WrEn;
                    r_mem_addr   <= bus.iM1_Addr;
                    r_mem_wrdata <= bus.iM1_WrData;
                    r_mem_funct3 <= bus.iM1_Funct3;
                end else begin
                    r_mem_wren   <= bus.iM0_WrEn;
                    r_mem_addr   <= bus.iM0_Addr;
                    r_mem_wrdata <= bus.iM0_WrData;
                    r_mem_funct3 <= bus.iM0_Funct3;
                end
            end
            if (r_state == c_S_ISSUE) begin
                r_lat <= c_LAT_INIT;
            end else if ((r_state == c_S_RD_WAIT) && (r_lat != 2'd0)) begin
                r_lat <= r_lat - 2'd1;
            end
        end
    end

    // Output logic
    assign w_rd_valid = (r_state == c_S_RD_WAIT) && (r_lat == 2'd0);

    always_comb begin
        bus.oM0_Gnt     = w_grant & ~w_sel_m1;
        bus.oM1_Gnt     = w_grant &  w_sel_m1;
        bus.oM0_RdValid = w_rd_valid & ~r_owner;
        bus.oM1_RdValid = w_rd_valid &  r_owner;
        bus.oM0_RdData  = (w_rd_valid & ~r_owner) ? bus.iMem_RdData : '0;
        bus.oM1_RdData  = (w_rd_valid &  r_owner) ? bus.iMem_RdData : '0;
        bus.oMem_WrEn   = r_mem_wren;
        bus.oMem_Addr   = r_mem_addr;
        bus.oMem_WrData = r_mem_wrdata;
        bus.oMem_Funct3 = r_mem_funct3;
        bus.oBusy       = (r_state != c_S_IDLE);
    end
endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_data_bus_arbiter
// Description: Self-checking bench for data_bus_arbiter. Two instances are
//              built: index 0 with RD_LATENCY=1, index 1 with RD_LATENCY=3.
//              Each is backed by a read-only memory with a delay pipeline
//              matching its latency. Directed scenarios are followed by a
//              randomized run checked against a transaction-level model.
// Revision   : 1.0  initial release
// ============================================================================
module tb_data_bus_arbiter;
`ifdef DBUS_ARB_FIXED_PRIO_EN
    localparam bit c_FIXED = 1'b1;
`else
    localparam bit c_FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    logic        req  [2][2];
    logic        wren [2][2];
    logic [31:0] addr [2][2];
    logic [31:0] wdat [2][2];
    logic [2:0]  f3   [2][2];
    logic        gnt  [2][2];
    logic        rdv  [2][2];
    logic [31:0] rdd  [2][2];
    logic        mwren[2];
    logic [31:0] maddr[2];
    logic [31:0] mwdat[2];
    logic [2:0]  mf3  [2];
    logic        busy [2];

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h20) return 32'h12345678;
        return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int c_L = (d == 0) ? 1 : 3;
        data_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        logic [31:0] r_pipe [4];

        assign bus.iM0_Req    = req[d][0];
        assign bus.iM0_WrEn   = wren[d][0];
        assign bus.iM0_Addr   = addr[d][0];
        assign bus.iM0_WrData = wdat[d][0];
        assign bus.iM0_Funct3 = f3[d][0];
        assign bus.iM1_Req    = req[d][1];
        assign bus.iM1_WrEn   = wren[d][1];
        assign bus.iM1_Addr   = addr[d][1];
        assign bus.iM1_WrData = wdat[d][1];
        assign bus.iM1_Funct3 = f3[d][1];
        assign gnt[d][0]      = bus.oM0_Gnt;
        assign gnt[d][1]      = bus.oM1_Gnt;
        assign rdv[d][0]      = bus.oM0_RdValid;
        assign rdv[d][1]      = bus.oM1_RdValid;
        assign rdd[d][0]      = bus.oM0_RdData;
        assign rdd[d][1]      = bus.oM1_RdData;
        assign mwren[d]       = bus.oMem_WrEn;
        assign maddr[d]       = bus.oMem_Addr;
        assign mwdat[d]       = bus.oMem_WrData;
        assign mf3[d]         = bus.oMem_Funct3;
        assign busy[d]        = bus.oBusy;
        assign bus.iMem_RdData = r_pipe[c_L-1];

        always @(posedge clk) begin
            r_pipe[0] <= rom(bus.oMem_Addr);
            r_pipe[1] <= r_pipe[0];
            r_pipe[2] <= r_pipe[1];
            r_pipe[3] <= r_pipe[2];
        end

        data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(c_L)) u_dut (
            .iClk (clk),
            .iRst (rst),
            .bus  (bus)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; wren[d][m] = 1'b0; addr[d][m] = '0;
                wdat[d][m] = '0;  f3[d][m] = 3'd0;
            end
    endtask

    task automatic set_req(input int d, input int m, input logic we,
                           input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f);
        req[d][m] = 1'b1; wren[d][m] = we; addr[d][m] = a; wdat[d][m] = wd; f3[d][m] = f;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        req[0][0] = 1'b1; req[1][1] = 1'b1;
        tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({busy[d], mwren[d], gnt[d][0], gnt[d][1], rdv[d][0], rdv[d][1]} !== 6'b0)
                $display("FAIL reset_ctrl d=%0d got %b exp 000000", d,
                         {busy[d], mwren[d], gnt[d][0], gnt[d][1], rdv[d][0], rdv[d][1]});
            else n_pass++;
            n_chk++;
            if ({maddr[d], mwdat[d], mf3[d], rdd[d][0], rdd[d][1]} !== '0)
                $display("FAIL reset_data d=%0d got addr=%h wd=%h f3=%0d rd0=%h rd1=%h exp all 0",
                         d, maddr[d], mwdat[d], mf3[d], rdd[d][0], rdd[d][1]);
            else n_pass++;
        end
        tick();
        idle_all();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        idle_all();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if ({busy[d], mwren[d], gnt[d][0], gnt[d][1], rdv[d][0], rdv[d][1]} !== 6'b0)
                    $display("FAIL idle d=%0d cyc=%0d got %b exp 000000", d, k,
                             {busy[d], mwren[d], gnt[d][0], gnt[d][1], rdv[d][0], rdv[d][1]});
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_store();
        set_req(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
        @(negedge clk);
        n_chk++;
        if ({gnt[0][0], gnt[0][1], busy[0]} !== 3'b100)
            $display("FAIL store_gnt got %b exp 100", {gnt[0][0], gnt[0][1], busy[0]});
        else n_pass++;
        tick();
        req[0][0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({mwren[0], busy[0], gnt[0][0], maddr[0], mwdat[0], mf3[0]} !==
            {1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'd2})
            $display("FAIL store_cmd got we=%b busy=%b g=%b a=%h d=%h f3=%0d exp 1 1 0 10 deadbeef 2",
                     mwren[0], busy[0], gnt[0][0], maddr[0], mwdat[0], mf3[0]);
        else n_pass++;
        tick();
        @(negedge clk);
        n_chk++;
        if ({mwren[0], busy[0], maddr[0]} !== {2'b00, 32'h10})
            $display("FAIL store_done got we=%b busy=%b a=%h exp 0 0 10", mwren[0], busy[0], maddr[0]);
        else n_pass++;
        tick();
    endtask

    task automatic test_load();
        set_req(0, 1, 1'b0, 32'h20, 32'h0, 3'd2);
        @(negedge clk);
        n_chk++;
        if ({gnt[0][0], gnt[0][1]} !== 2'b01)
            $display("FAIL load_gnt got %b exp 01", {gnt[0][0], gnt[0][1]});
        else n_pass++;
        tick();
        req[0][1] = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({mwren[0], maddr[0], rdv[0][0], rdv[0][1]} !== {1'b0, 32'h20, 2'b00})
            $display("FAIL load_cmd got we=%b a=%h rv=%b%b exp 0 20 00",
                     mwren[0], maddr[0], rdv[0][0], rdv[0][1]);
        else n_pass++;
        tick();
        @(negedge clk);
        n_chk++;
        if ({rdv[0][0], rdv[0][1], rdd[0][0], rdd[0][1]} !== {2'b01, 32'h0, 32'h12345678})
            $display("FAIL load_data got rv=%b%b rd0=%h rd1=%h exp 01 0 12345678",
                     rdv[0][0], rdv[0][1], rdd[0][0], rdd[0][1]);
        else n_pass++;
        tick();
        @(negedge clk);
        n_chk++;
        if ({busy[0], rdv[0][1]} !== 2'b00)
            $display("FAIL load_done got busy=%b rv1=%b exp 0 0", busy[0], rdv[0][1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] eg, erv;
        int w;
        set_req(0, 0, 1'b0, 32'h100, 32'h0, 3'd2);
        set_req(0, 1, 1'b0, 32'h104, 32'h0, 3'd2);
        for (int k = 0; k < 12; k++) begin
            w = c_FIXED ? 0 : ((k / 3) % 2);
            eg  = (k % 3 == 0) ? ((w == 1) ? 2'b01 : 2'b10) : 2'b00;
            erv = (k % 3 == 2) ? ((w == 1) ? 2'b01 : 2'b10) : 2'b00;
            @(negedge clk);
            n_chk++;
            if ({gnt[0][0], gnt[0][1]} !== eg)
                $display("FAIL rr_gnt cyc=%0d got %b exp %b", k, {gnt[0][0], gnt[0][1]}, eg);
            else n_pass++;
            n_chk++;
            if ({rdv[0][0], rdv[0][1]} !== erv)
                $display("FAIL rr_rdv cyc=%0d got %b exp %b", k, {rdv[0][0], rdv[0][1]}, erv);
            else n_pass++;
            if (k % 3 == 2) begin
                n_chk++;
                if (rdd[0][w] !== rom((w == 1) ? 32'h104 : 32'h100))
                    $display("FAIL rr_data cyc=%0d got %h exp %h", k, rdd[0][w],
                             rom((w == 1) ? 32'h104 : 32'h100));
                else n_pass++;
            end
            tick();
        end
        idle_all();
        repeat (4) tick();
    endtask

    task automatic test_latency3();
        set_req(1, 0, 1'b0, 32'h40, 32'h0, 3'd4);
        @(negedge clk);
        n_chk++;
        if ({gnt[1][0], gnt[1][1]} !== 2'b10)
            $display("FAIL lat3_gnt got %b exp 10", {gnt[1][0], gnt[1][1]});
        else n_pass++;
        tick();
        req[1][0] = 1'b0;
        set_req(1, 1, 1'b1, 32'h44, 32'hCAFEF00D, 3'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_chk++;
            if ({gnt[1][1], rdv[1][0], busy[1]} !== {1'b0, (k == 4), 1'b1})
                $display("FAIL lat3_wait cyc=N+%0d got g1=%b rv0=%b busy=%b exp 0 %0d 1",
                         k, gnt[1][1], rdv[1][0], busy[1], (k == 4));
            else n_pass++;
            if (k == 4) begin
                n_chk++;
                if (rdd[1][0] !== rom(32'h40))
                    $display("FAIL lat3_data got %h exp %h", rdd[1][0], rom(32'h40));
                else n_pass++;
            end
            tick();
        end
        @(negedge clk);
        n_chk++;
        if ({gnt[1][0], gnt[1][1], busy[1]} !== 3'b010)
            $display("FAIL lat3_m1_gnt got %b exp 010", {gnt[1][0], gnt[1][1], busy[1]});
        else n_pass++;
        tick();
        req[1][1] = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({mwren[1], maddr[1], mwdat[1]} !== {1'b1, 32'h44, 32'hCAFEF00D})
            $display("FAIL lat3_store got we=%b a=%h d=%h exp 1 44 cafef00d", mwren[1], maddr[1], mwdat[1]);
        else n_pass++;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        set_req(1, 0, 1'b0, 32'h48, 32'h0, 3'd2);
        @(negedge clk);
        n_chk++;
        if (gnt[1][0] !== 1'b1) $display("FAIL rmid_gnt got %b exp 1", gnt[1][0]);
        else n_pass++;
        tick();
        req[1][0] = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (rdv[1][0] !== 1'b0) $display("FAIL rmid_rdv_in_rst got %b exp 0", rdv[1][0]);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({busy[1], mwren[1], rdv[1][0], rdv[1][1], gnt[1][0], gnt[1][1], maddr[1], rdd[1][0]} !== '0)
            $display("FAIL rmid_after got busy=%b we=%b rv=%b%b a=%h rd0=%h exp all 0",
                     busy[1], mwren[1], rdv[1][0], rdv[1][1], maddr[1], rdd[1][0]);
        else n_pass++;
        tick();
        set_req(1, 0, 1'b0, 32'h50, 32'h0, 3'd2);
        set_req(1, 1, 1'b0, 32'h54, 32'h0, 3'd2);
        @(negedge clk);
        n_chk++;
        if ({gnt[1][0], gnt[1][1], rdv[1][0]} !== 3'b100)
            $display("FAIL rmid_tie got g=%b%b rv0=%b exp 10 0", gnt[1][0], gnt[1][1], rdv[1][0]);
        else n_pass++;
        tick();
        idle_all();
        repeat (6) tick();
    endtask

    // Transaction-level reference: on each cycle an idle arbiter grants one
    // requester, which schedules a command one cycle later and (for a read)
    // a return L cycles after that; the arbiter is free again afterwards.
    task automatic test_random();
        int          free_at [2];
        bit          last1   [2];
        bit          cv [2][8];
        bit          cwe[2][8];
        logic [31:0] ca [2][8];
        logic [31:0] cwd[2][8];
        logic [2:0]  cf [2][8];
        bit          vv [2][8];
        bit          vm [2][8];
        logic [31:0] vd [2][8];
        logic [31:0] ha [2];
        logic [31:0] hwd[2];
        logic [2:0]  hf [2];
        bit          seen[2][2];
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            free_at[d] = 0; last1[d] = 1'b1; ha[d] = '0; hwd[d] = '0; hf[d] = '0;
            for (int s = 0; s < 8; s++) begin cv[d][s] = 1'b0; vv[d][s] = 1'b0; end
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int s, w, L;
                bit eb, ewe;
                logic [1:0] eg, erv;
                logic [31:0] e0, e1;
                L = lat_of(d);
                s = cyc % 8;
                eb = (cyc < free_at[d]);
                eg = 2'b00;
                if (!eb && (req[d][0] || req[d][1])) begin
                    if (req[d][0] && req[d][1]) w = c_FIXED ? 0 : (last1[d] ? 0 : 1);
                    else w = req[d][1] ? 1 : 0;
                    last1[d] = (w == 1);
                    eg = (w == 1) ? 2'b01 : 2'b10;
                    cv[d][(cyc+1)%8] = 1'b1;  cwe[d][(cyc+1)%8] = wren[d][w];
                    ca[d][(cyc+1)%8] = addr[d][w]; cwd[d][(cyc+1)%8] = wdat[d][w];
                    cf[d][(cyc+1)%8] = f3[d][w];
                    if (!wren[d][w]) begin
                        vv[d][(cyc+1+L)%8] = 1'b1; vm[d][(cyc+1+L)%8] = (w == 1);
                        vd[d][(cyc+1+L)%8] = rom(addr[d][w]);
                    end
                    free_at[d] = cyc + 2 + (wren[d][w] ? 0 : L);
                end
                ewe = 1'b0;
                if (cv[d][s]) begin
                    ha[d] = ca[d][s]; hwd[d] = cwd[d][s]; hf[d] = cf[d][s]; ewe = cwe[d][s];
                    cv[d][s] = 1'b0;
                end
                erv = 2'b00; e0 = '0; e1 = '0;
                if (vv[d][s]) begin
                    if (vm[d][s]) begin erv = 2'b01; e1 = vd[d][s]; end
                    else          begin erv = 2'b10; e0 = vd[d][s]; end
                    vv[d][s] = 1'b0;
                end
                n_chk++;
                if ({gnt[d][0], gnt[d][1]} !== eg)
                    $display("FAIL rnd_gnt d=%0d cyc=%0d got %b exp %b", d, cyc, {gnt[d][0], gnt[d][1]}, eg);
                else n_pass++;
                n_chk++;
                if (busy[d] !== eb)
                    $display("FAIL rnd_busy d=%0d cyc=%0d got %b exp %b", d, cyc, busy[d], eb);
                else n_pass++;
                n_chk++;
                if ({mwren[d], maddr[d], mwdat[d], mf3[d]} !== {ewe, ha[d], hwd[d], hf[d]})
                    $display("FAIL rnd_mem d=%0d cyc=%0d got we=%b a=%h d=%h f3=%0d exp we=%b a=%h d=%h f3=%0d",
                             d, cyc, mwren[d], maddr[d], mwdat[d], mf3[d], ewe, ha[d], hwd[d], hf[d]);
                else n_pass++;
                n_chk++;
                if ({rdv[d][0], rdv[d][1]} !== erv)
                    $display("FAIL rnd_rdv d=%0d cyc=%0d got %b exp %b", d, cyc, {rdv[d][0], rdv[d][1]}, erv);
                else n_pass++;
                n_chk++;
                if ({rdd[d][0], rdd[d][1]} !== {e0, e1})
                    $display("FAIL rnd_rdata d=%0d cyc=%0d got %h/%h exp %h/%h", d, cyc,
                             rdd[d][0], rdd[d][1], e0, e1);
                else n_pass++;
                seen[d][0] = gnt[d][0];
                seen[d][1] = gnt[d][1];
            end
            tick();
            // Requesters hold fields until granted, then pick a new action.
            for (int d = 0; d < 2; d++)
                for (int m = 0; m < 2; m++)
                    if (!req[d][m] || seen[d][m]) begin
                        if ($urandom_range(0, 2) != 0)
                            set_req(d, m, 1'($urandom_range(0, 1)), $urandom, $urandom,
                                    3'($urandom_range(0, 7)));
                        else
                            req[d][m] = 1'b0;
                    end
        end
        idle_all();
        repeat (6) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle();
        test_store();
        test_load();
        test_round_robin();
        test_latency3();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
